dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a load/store unit and the data memory controller.
interface dmem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_busy;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with byte/half/word access, alignment and range
// checking, and an optional zero-fill sweep after reset.
module dmem_ctrl #(
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input logic       clk,
   input logic       rstn,
   dmem_ctrl_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

   logic [31:0] mem [DEPTH];

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic               ready_q, busy_q;

   logic [ADDR_W-1:0]  req_idx;
   logic [1:0]         req_lane;
   logic               req_bad;
   logic [3:0]         req_be;
   logic [31:0]        req_wrep;
   logic [31:0]        rd_word;
   logic [7:0]         rd_byte;
   logic [15:0]        rd_half;
   logic [31:0]        load_data;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_idx;
   logic [3:0]         mem_be;
   logic [31:0]        mem_wdata;

   // Decode the current request: index, lane, error, byte enables, store data and load result
   always_comb begin
      req_idx   = bus.req_addr[ADDR_W+1:2];
      req_lane  = bus.req_addr[1:0];
      rd_word   = mem[req_idx];
      rd_byte   = rd_word[{req_lane, 3'b000} +: 8];
      rd_half   = rd_word[{req_lane[1], 4'b0000} +: 16];
      req_bad   = ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
      req_be    = 4'b1111;
      req_wrep  = bus.req_wdata;
      load_data = rd_word;
      unique case (bus.req_size)
         SZ_BYTE: begin
            req_be    = 4'(4'b0001 << req_lane);
            req_wrep  = {4{bus.req_wdata[7:0]}};
            load_data = {(bus.req_unsigned ? 24'h0 : {24{rd_byte[7]}}), rd_byte};
         end
         SZ_HALF: begin
            req_be    = req_lane[1] ? 4'b1100 : 4'b0011;
            req_wrep  = {2{bus.req_wdata[15:0]}};
            load_data = {(bus.req_unsigned ? 16'h0 : {16{rd_half[15]}}), rd_half};
            if (req_lane[0]) req_bad = 1'b1;
         end
         SZ_WORD: begin
            if (req_lane != 2'b00) req_bad = 1'b1;
         end
         default: begin
            req_bad = 1'b1;
         end
      endcase
   end

   // Next-state, sweep counter, memory write port and response values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0;
      rsp_err_d   = 1'b0;
      mem_we      = 1'b0;
      mem_idx     = req_idx;
      mem_be      = req_be;
      mem_wdata   = req_wrep;
      unique case (state_q)
         ST_INIT: begin
            if (rstn) begin
               mem_we    = 1'b1;
               mem_idx   = cnt_q[ADDR_W-1:0];
               mem_be    = 4'b1111;
               mem_wdata = 32'h0;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rstn && bus.req_valid) begin
               rsp_valid_d = 1'b1;
               if (req_bad) begin
                  rsp_err_d = 1'b1;
               end else if (bus.req_we) begin
                  mem_we = 1'b1;
               end else begin
                  rsp_rdata_d = load_data;
               end
            end
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   // State, counter and registered outputs; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= RESET_STATE;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         ready_q     <= (RESET_STATE == ST_RUN);
         busy_q      <= (RESET_STATE == ST_INIT);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         ready_q     <= (state_d == ST_RUN);
         busy_q      <= (state_d == ST_INIT);
      end
   end

   // Byte-masked memory write; contents are not reset so they survive when the sweep is disabled
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.init_busy = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
